act_mem_line_writer: RTL and testbench

//  Upstream fill stage for the activation memory.
//  - Accepts narrow activation beats on a valid/ready stream and packs IN_WIDTH/8 bytes per beat into a WIDTH-bit line.
//  - Issues one full-line write per assembled line on the activation memory's port A (address, data, byte enables, write enable).
//  - Writes i_num_lines consecutive lines starting at i_base_addr, then pulses o_done.

---
 rtl/act_mem_line_writer.sv | 218 +++++++++++++++++++++
 tb/tb_act_mem_line_writer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_mem_line_writer.sv
// ---------------------------------------------------------------------------
// act_mem_line_writer
//
// Upstream fill stage for the activation memory. Narrow activation beats are
// packed into a WIDTH-bit line buffer. Each assembled line goes out as one
// full-line write on memory port A. A transfer writes i_num_lines consecutive
// lines starting at i_base_addr, then pulses o_done.
//
// Handshake: a beat transfers on a rising edge where s_valid & s_ready are
// both high. s_ready is registered and is high only in FILL. s_valid may be
// raised or dropped at any time; it is ignored while s_ready is low.
//
// Optional feature macro: ACT_WR_PARTIAL_FLUSH_EN
//   Adds input i_flush. In FILL with no handshake that cycle, i_flush
//   writes the partially filled line with byte enables for the filled lanes
//   only, then ends the transfer. With an empty line it ends the transfer
//   without writing.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   i_start               start a transfer (sampled only in IDLE)
//   i_base_addr           first line address, latched on start
//   i_num_lines           number of lines to write, latched on start (0 ok)
//   s_valid/s_data/s_ready input beat stream; beat k fills lane k
//   address_a/data_a/o_be_a/wren_a  memory port A write interface
//   o_busy                high in every state except IDLE
//   o_done                one-cycle completion pulse
//   i_flush               (ACT_WR_PARTIAL_FLUSH_EN only) partial-line flush
//
// Debug: the FSM state is held in state_q (type state_t).
// ---------------------------------------------------------------------------
module act_mem_line_writer #(
    parameter int WIDTH      = 512,
    parameter int ADDR_WIDTH = 3,
    parameter int IN_WIDTH   = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_num_lines,
`ifdef ACT_WR_PARTIAL_FLUSH_EN
    input  logic                  i_flush,
`endif
    input  logic                  s_valid,
    input  logic [IN_WIDTH-1:0]   s_data,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] address_a,
    output logic [WIDTH-1:0]      data_a,
    output logic [WIDTH/8-1:0]    o_be_a,
    output logic                  wren_a,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int BEATS = WIDTH / IN_WIDTH;
    localparam int LANES = IN_WIDTH / 8;
    localparam int BE_W  = WIDTH / 8;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [ADDR_WIDTH:0]   lines_left_q, lines_left_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [WIDTH-1:0]      buffer_q, buffer_d;
    logic                  flush_last_q, flush_last_d;
    logic [ADDR_WIDTH-1:0] address_a_q, address_a_d;
    logic [WIDTH-1:0]      data_a_q, data_a_d;
    logic [BE_W-1:0]       be_a_q, be_a_d;
    logic                  wren_a_q, wren_a_d;
    logic                  s_ready_q, s_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  handshake;
    logic                  last_beat;

    assign handshake = s_valid && s_ready_q;
    assign last_beat = (beat_cnt_q == CNT_W'(BEATS - 1));

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        lines_left_d = lines_left_q;
        cur_addr_d   = cur_addr_q;
        buffer_d     = buffer_q;
        flush_last_d = flush_last_q;
        address_a_d  = address_a_q;
        data_a_d     = data_a_q;
        be_a_d       = be_a_q;
        wren_a_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    cur_addr_d   = i_base_addr;
                    lines_left_d = i_num_lines;
                    beat_cnt_d   = '0;
                    flush_last_d = 1'b0;
                    state_d      = (i_num_lines == '0) ? ST_DONE : ST_FILL;
                end
            end

            ST_FILL: begin
                if (handshake) begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (beat_cnt_q == CNT_W'(b)) begin
                            buffer_d[b*IN_WIDTH +: IN_WIDTH] = s_data;
                        end
                    end
                    if (last_beat) begin
                        // Present the line including the beat taken this cycle.
                        beat_cnt_d  = '0;
                        state_d     = ST_WRITE;
                        wren_a_d    = 1'b1;
                        address_a_d = cur_addr_q;
                        data_a_d    = buffer_d;
                        be_a_d      = '1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
`ifdef ACT_WR_PARTIAL_FLUSH_EN
                else if (i_flush) begin
                    if (beat_cnt_q != '0) begin
                        // Enable only lanes 0..beat_cnt-1.
                        be_a_d = '0;
                        for (int b = 0; b < BEATS; b++) begin
                            if (CNT_W'(b) < beat_cnt_q) begin
                                be_a_d[b*LANES +: LANES] = '1;
                            end
                        end
                        beat_cnt_d   = '0;
                        state_d      = ST_WRITE;
                        wren_a_d     = 1'b1;
                        address_a_d  = cur_addr_q;
                        data_a_d     = buffer_q;
                        flush_last_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
`endif
            end

            ST_WRITE: begin
                cur_addr_d   = cur_addr_q + 1'b1;
                lines_left_d = lines_left_q - 1'b1;
                // lines_left_q == 1 means this was the final line.
                if (flush_last_q || (lines_left_q == (ADDR_WIDTH+1)'(1))) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FILL;
                end
            end

            ST_DONE: begin
                flush_last_d = 1'b0;
                state_d      = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        // Registered status outputs follow the next state.
        s_ready_d = (state_d == ST_FILL);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= '0;
            lines_left_q <= '0;
            cur_addr_q   <= '0;
            buffer_q     <= '0;
            flush_last_q <= 1'b0;
            address_a_q  <= '0;
            data_a_q     <= '0;
            be_a_q       <= '0;
            wren_a_q     <= 1'b0;
            s_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            lines_left_q <= lines_left_d;
            cur_addr_q   <= cur_addr_d;
            buffer_q     <= buffer_d;
            flush_last_q <= flush_last_d;
            address_a_q  <= address_a_d;
            data_a_q     <= data_a_d;
            be_a_q       <= be_a_d;
            wren_a_q     <= wren_a_d;
            s_ready_q    <= s_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign address_a = address_a_q;
    assign data_a    = data_a_q;
    assign o_be_a    = be_a_q;
    assign wren_a    = wren_a_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;

endmodule

// File: tb/tb_act_mem_line_writer.sv
// Bench for act_mem_line_writer: table of transfers plus corner sequences.
module tb_act_mem_line_writer;

  localparam int WIDTH      = 512;
  localparam int ADDR_WIDTH = 3;
  localparam int IN_WIDTH   = 64;
  localparam int BEATS      = WIDTH / IN_WIDTH;
  localparam int LANES      = IN_WIDTH / 8;
  localparam int BE_W       = WIDTH / 8;
  localparam int EXP_W      = ADDR_WIDTH + BE_W + WIDTH;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic                  i_start = 1'b0;
  logic [ADDR_WIDTH-1:0] i_base_addr = '0;
  logic [ADDR_WIDTH:0]   i_num_lines = '0;
`ifdef ACT_WR_PARTIAL_FLUSH_EN
  logic                  i_flush = 1'b0;
`endif
  logic                  s_valid = 1'b0;
  logic [IN_WIDTH-1:0]   s_data = '0;
  logic                  s_ready;
  logic [ADDR_WIDTH-1:0] address_a;
  logic [WIDTH-1:0]      data_a;
  logic [BE_W-1:0]       o_be_a;
  logic                  wren_a;
  logic                  o_busy;
  logic                  o_done;

  act_mem_line_writer #(
    .WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .IN_WIDTH(IN_WIDTH)
  ) dut (
    .clock(clock), .reset(reset), .i_start(i_start),
    .i_base_addr(i_base_addr), .i_num_lines(i_num_lines),
`ifdef ACT_WR_PARTIAL_FLUSH_EN
    .i_flush(i_flush),
`endif
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .address_a(address_a), .data_a(data_a), .o_be_a(o_be_a),
    .wren_a(wren_a), .o_busy(o_busy), .o_done(o_done)
  );

  // scoreboard state
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int beat_mon = 0;
  logic [ADDR_WIDTH-1:0] last_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // write monitor: every write is popped from the expected queue
  always @(negedge clock) begin
    if (!reset) begin
      if (s_valid && s_ready) beat_mon++;
      if (wren_a) begin
        logic [EXP_W-1:0]      e;
        logic [ADDR_WIDTH-1:0] e_addr;
        logic [BE_W-1:0]       e_be;
        logic [WIDTH-1:0]      e_data;
        logic [WIDTH-1:0]      mask;
        wr_cnt++;
        last_addr = address_a;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got write at addr %0d expected no write", address_a);
        end else begin
          e = exp_q.pop_front();
          {e_addr, e_be, e_data} = e;
          for (int i = 0; i < BE_W; i++) mask[i*8 +: 8] = {8{e_be[i]}};
          if (address_a !== e_addr || o_be_a !== e_be || (data_a & mask) !== (e_data & mask)) begin
            errors++;
            $display("FAIL write: got addr %0d be %h data %h expected addr %0d be %h data %h",
                     address_a, o_be_a, data_a & mask, e_addr, e_be, e_data & mask);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic do_start(input logic [ADDR_WIDTH-1:0] base, input logic [ADDR_WIDTH:0] lines);
    i_base_addr = base;
    i_num_lines = lines;
    i_start = 1'b1;
    @(posedge clock); #1;
    i_start = 1'b0;
  endtask

  task automatic feed_beat(input logic [IN_WIDTH-1:0] d);
    logic acc;
    acc = 1'b0;
    s_valid = 1'b1;
    s_data = d;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clock);
      acc = s_ready;
      @(posedge clock); #1;
    end
    s_valid = 1'b0;
    if (!acc) check("beat_accept_timeout", 64'(acc), 64'd1);
  endtask

  // mode 0: back-to-back byte pattern, 1: one idle cycle between beats,
  // 2: random gaps and data. split>0 pulses i_start before that beat.
  task automatic feed_line(input logic [ADDR_WIDTH-1:0] addr, input int mode, input int split);
    logic [IN_WIDTH-1:0] beat [BEATS];
    logic [WIDTH-1:0] line;
    for (int b = 0; b < BEATS; b++) begin
      beat[b] = (mode == 0) ? {LANES{8'(b + 1)}} : {$urandom, $urandom};
      line[b*IN_WIDTH +: IN_WIDTH] = beat[b];
    end
    exp_q.push_back({addr, {BE_W{1'b1}}, line});
    for (int b = 0; b < BEATS; b++) begin
      if (split > 0 && b == split) begin
        i_base_addr = ~addr;
        i_num_lines = '0;
        i_start = 1'b1;
        @(posedge clock); #1;
        i_start = 1'b0;
      end
      feed_beat(beat[b]);
      if (b != BEATS - 1) begin
        if (mode == 1) begin
          @(posedge clock); #1;
        end else if (mode == 2) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clock); #1;
          end
        end
      end
    end
    @(negedge clock);
    check("wren_latency", 64'(wren_a), 64'd1);
    check("ready_low_in_write", 64'(s_ready), 64'd0);
  endtask

  task automatic check_done_tail();
    @(negedge clock);
    check("done_pulse", 64'(o_done), 64'd1);
    check("busy_in_done", 64'(o_busy), 64'd1);
    @(negedge clock);
    check("done_cleared", 64'(o_done), 64'd0);
    check("busy_cleared", 64'(o_busy), 64'd0);
  endtask

  typedef struct {
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH:0]   lines;
    int                    mode;
    int                    exp_writes;
    logic [ADDR_WIDTH-1:0] exp_last_addr;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int wr0, bt0;
    vecs[0] = '{base: 3'd2, lines: 4'd1, mode: 0, exp_writes: 1, exp_last_addr: 3'd2};
    vecs[1] = '{base: 3'd6, lines: 4'd3, mode: 1, exp_writes: 3, exp_last_addr: 3'd0};
    vecs[2] = '{base: 3'd5, lines: 4'd2, mode: 2, exp_writes: 2, exp_last_addr: 3'd6};
    vecs[3] = '{base: 3'd0, lines: 4'd8, mode: 2, exp_writes: 8, exp_last_addr: 3'd7};

    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_wren", 64'(wren_a), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_addr", 64'(address_a), 64'd0);
    check("rst_be", o_be_a, 64'd0);
    check("rst_data_or", 64'(|data_a), 64'd0);
    reset = 1'b0;

    // zero-line transfer: straight to DONE, busy for one cycle, no write
    wr0 = wr_cnt;
    @(negedge clock);
    do_start(3'd4, 4'd0);
    check_done_tail();
    check("zero_lines_writes", 64'(wr_cnt - wr0), 64'd0);

    // s_valid while IDLE is ignored
    bt0 = beat_mon;
    s_valid = 1'b1;
    s_data = 64'hDEAD_BEEF_DEAD_BEEF;
    repeat (4) begin
      @(negedge clock);
      check("idle_ready_low", 64'(s_ready), 64'd0);
    end
    s_valid = 1'b0;
    check("idle_no_beats", 64'(beat_mon - bt0), 64'd0);

    // i_start while busy is ignored: write still lands at addr 3
    wr0 = wr_cnt;
    do_start(3'd3, 4'd1);
    feed_line(3'd3, 2, 3);
    check_done_tail();
    check("busy_start_writes", 64'(wr_cnt - wr0), 64'd1);

    // table-driven transfers
    for (int v = 0; v < 4; v++) begin
      wr0 = wr_cnt;
      bt0 = beat_mon;
      do_start(vecs[v].base, vecs[v].lines);
      for (int l = 0; l < int'(vecs[v].lines); l++) begin
        feed_line(ADDR_WIDTH'(int'(vecs[v].base) + l), vecs[v].mode, 0);
      end
      check_done_tail();
      check("vec_writes", 64'(wr_cnt - wr0), 64'(vecs[v].exp_writes));
      check("vec_beats", 64'(beat_mon - bt0), 64'(vecs[v].exp_writes * BEATS));
      check("vec_last_addr", 64'(last_addr), 64'(vecs[v].exp_last_addr));
    end

    // reset after 5 beats: partial line abandoned, nothing written
    wr0 = wr_cnt;
    do_start(3'd5, 4'd1);
    for (int b = 0; b < 5; b++) feed_beat({$urandom, $urandom});
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("midrst_wren", 64'(wren_a), 64'd0);
    check("midrst_ready", 64'(s_ready), 64'd0);
    check("midrst_busy", 64'(o_busy), 64'd0);
    repeat (12) @(negedge clock);
    check("midrst_no_write", 64'(wr_cnt - wr0), 64'd0);
    check("midrst_idle_ready", 64'(s_ready), 64'd0);

`ifdef ACT_WR_PARTIAL_FLUSH_EN
    // three beats then flush: one partial write, then done
    begin
      logic [WIDTH-1:0] line;
      logic [IN_WIDTH-1:0] d [3];
      line = '0;
      for (int b = 0; b < 3; b++) begin
        d[b] = {$urandom, $urandom};
        line[b*IN_WIDTH +: IN_WIDTH] = d[b];
      end
      wr0 = wr_cnt;
      exp_q.push_back({3'd1, 64'h0000_0000_00FF_FFFF, line});
      do_start(3'd1, 4'd2);
      for (int b = 0; b < 3; b++) feed_beat(d[b]);
      i_flush = 1'b1;
      @(posedge clock); #1;
      i_flush = 1'b0;
      @(negedge clock);
      check("flush_wren", 64'(wren_a), 64'd1);
      check("flush_be", o_be_a, 64'h0000_0000_00FF_FFFF);
      check_done_tail();
      check("flush_writes", 64'(wr_cnt - wr0), 64'd1);

      // flush on an empty line ends the transfer without a write
      wr0 = wr_cnt;
      do_start(3'd2, 4'd1);
      i_flush = 1'b1;
      @(posedge clock); #1;
      i_flush = 1'b0;
      @(negedge clock);
      check("flush_empty_done", 64'(o_done), 64'd1);
      check("flush_empty_writes", 64'(wr_cnt - wr0), 64'd0);
      repeat (2) @(negedge clock);
    end
`endif

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
